// File: rtl/bus_err_unit_id.sv
// rtl/bus_err_unit_id.sv - ID-aware bus error unit with per-channel tracking and shared error FIFO
//
// Tracks outstanding requests per (channel, ID). Erroring response beats become
// records that land in one-deep per-channel stages. A round-robin arbiter pushes
// one stage per cycle into a shared error FIFO.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   testmode_i               FIFO test-mode passthrough (no effect on this FIFO)
//   req_*_i                  per-channel request handshake, ID, address, metadata
//   rsp_*_i                  per-channel response handshake, ID, last beat, error code
//   drop_clr_i               clears drop_cnt_o and id_collision_o
//   err_fifo_pop_i           pops the head error entry
//   err_irq_o                FIFO not empty
//   err_*_o                  head entry fields (zero while empty)
//   err_fifo_overflow_o      FIFO full
//   drop_cnt_o               saturating count of lost errors
//   id_collision_o           sticky: request reused an outstanding ID
module bus_err_unit_id #(
    parameter int AddrWidth       = 48,
    parameter int MetaDataWidth   = 1,
    parameter int ErrBits         = 3,
    parameter int IdWidth         = 2,
    parameter int NumChannels     = 2,
    parameter int NumStoredErrors = 4,
    parameter int DropCntWidth    = 8,
    parameter bit DropOldest      = 1'b0,
    localparam int ChanW          = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 testmode_i,
    input  logic [NumChannels-1:0]               req_valid_i,
    input  logic [NumChannels*IdWidth-1:0]       req_id_i,
    input  logic [NumChannels*AddrWidth-1:0]     req_addr_i,
    input  logic [NumChannels*MetaDataWidth-1:0] req_meta_i,
    input  logic [NumChannels-1:0]               rsp_valid_i,
    input  logic [NumChannels*IdWidth-1:0]       rsp_id_i,
    input  logic [NumChannels-1:0]               rsp_last_i,
    input  logic [NumChannels*ErrBits-1:0]       rsp_err_i,
    input  logic                                 drop_clr_i,
    input  logic                                 err_fifo_pop_i,
    output logic                                 err_irq_o,
    output logic [ErrBits-1:0]                   err_code_o,
    output logic [AddrWidth-1:0]                 err_addr_o,
    output logic [MetaDataWidth-1:0]             err_meta_o,
    output logic [ChanW-1:0]                     err_chan_o,
    output logic [IdWidth-1:0]                   err_id_o,
    output logic                                 err_unknown_o,
    output logic                                 err_fifo_overflow_o,
    output logic [DropCntWidth-1:0]              drop_cnt_o,
    output logic                                 id_collision_o
);
    localparam int NumIds  = 2 ** IdWidth;
    localparam int TabSize = NumChannels * NumIds;
    localparam int TabW    = (TabSize > 1) ? $clog2(TabSize) : 1;
    localparam int PtrW    = $clog2(NumStoredErrors);
    localparam int CntW    = $clog2(NumStoredErrors + 1);
    localparam int IncW    = $clog2(NumChannels + 2);

    typedef struct packed {
        logic [ErrBits-1:0]       err;
        logic [AddrWidth-1:0]     addr;
        logic [MetaDataWidth-1:0] meta;
        logic [ChanW-1:0]         chan;
        logic [IdWidth-1:0]       id;
        logic                     unknown;
    } rec_t;

    logic unused_testmode;
    assign unused_testmode = testmode_i;

    // Tracking table
    logic [TabSize-1:0]       tab_valid_q, tab_valid_d;
    logic [AddrWidth-1:0]     tab_addr_q [TabSize];
    logic [AddrWidth-1:0]     tab_addr_d [TabSize];
    logic [MetaDataWidth-1:0] tab_meta_q [TabSize];
    logic [MetaDataWidth-1:0] tab_meta_d [TabSize];
    logic                     collision_set;
    rec_t                     rec [NumChannels];
    logic [NumChannels-1:0]   rec_valid;

    always_comb begin
        logic [TabW-1:0] ridx;
        logic [TabW-1:0] qidx;
        logic            freed;
        tab_valid_d   = tab_valid_q;
        tab_addr_d    = tab_addr_q;
        tab_meta_d    = tab_meta_q;
        collision_set = 1'b0;
        rec_valid     = '0;
        ridx          = '0;
        qidx          = '0;
        freed         = 1'b0;
        for (int c = 0; c < NumChannels; c++) begin
            ridx = TabW'(c * NumIds) + TabW'(rsp_id_i[c*IdWidth +: IdWidth]);
            qidx = TabW'(c * NumIds) + TabW'(req_id_i[c*IdWidth +: IdWidth]);
            // Lookup always sees the pre-edge entry, so a same-cycle request
            // cannot affect the response it races with.
            rec[c].err     = rsp_err_i[c*ErrBits +: ErrBits];
            rec[c].addr    = tab_valid_q[ridx] ? tab_addr_q[ridx] : '0;
            rec[c].meta    = tab_valid_q[ridx] ? tab_meta_q[ridx] : '0;
            rec[c].chan    = ChanW'(c);
            rec[c].id      = rsp_id_i[c*IdWidth +: IdWidth];
            rec[c].unknown = ~tab_valid_q[ridx];
            rec_valid[c]   = rsp_valid_i[c] && (rec[c].err != '0);
            freed = rsp_valid_i[c] && rsp_last_i[c] && (ridx == qidx);
            if (rsp_valid_i[c] && rsp_last_i[c]) begin
                tab_valid_d[ridx] = 1'b0;
            end
            // Request is applied after the response so it wins on the same entry;
            // an entry being retired this cycle counts as free.
            if (req_valid_i[c]) begin
                if (tab_valid_q[qidx] && !freed) begin
                    tab_valid_d[qidx] = 1'b0;
                    collision_set     = 1'b1;
                end else begin
                    tab_valid_d[qidx] = 1'b1;
                    tab_addr_d[qidx]  = req_addr_i[c*AddrWidth +: AddrWidth];
                    tab_meta_d[qidx]  = req_meta_i[c*MetaDataWidth +: MetaDataWidth];
                end
            end
        end
    end

    // Stages and round-robin arbitration
    rec_t                   stage_q [NumChannels];
    rec_t                   stage_d [NumChannels];
    logic [NumChannels-1:0] stage_valid_q, stage_valid_d;
    logic [ChanW-1:0]       rr_q, rr_d;
    logic                   gnt_any;
    logic [ChanW-1:0]       gnt_idx;
    logic [IncW-1:0]        stage_drops;
    logic                   fifo_full;

    always_comb begin
        logic [ChanW-1:0] cand;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NumChannels; k++) begin
            cand = ChanW'((int'(rr_q) + k) % NumChannels);
            if (!gnt_any && stage_valid_q[cand] && (!fifo_full || DropOldest)) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        rr_d = gnt_any ? ChanW'((int'(gnt_idx) + 1) % NumChannels) : rr_q;
    end

    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_d       = stage_q;
        stage_drops   = '0;
        for (int c = 0; c < NumChannels; c++) begin
            if (gnt_any && gnt_idx == ChanW'(c)) begin
                stage_valid_d[c] = 1'b0;
            end
            if (rec_valid[c]) begin
                if (!stage_valid_q[c] || (gnt_any && gnt_idx == ChanW'(c))) begin
                    stage_d[c]       = rec[c];
                    stage_valid_d[c] = 1'b1;
                end else begin
                    stage_drops = stage_drops + IncW'(1);
                end
            end
        end
    end

    // Error FIFO
    rec_t            fifo_q [NumStoredErrors];
    rec_t            fifo_d [NumStoredErrors];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            pop_eff, oldest_drop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(NumStoredErrors - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full = (count_q == CntW'(NumStoredErrors));

    always_comb begin
        fifo_d      = fifo_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        pop_eff     = err_fifo_pop_i && (count_q != '0);
        // Only reachable with DropOldest: grants are blocked on full otherwise.
        oldest_drop = gnt_any && fifo_full && !pop_eff;
        if (gnt_any) begin
            fifo_d[wptr_q] = stage_q[gnt_idx];
            wptr_d         = ptr_inc(wptr_q);
        end
        if (pop_eff || oldest_drop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        if (gnt_any && !(pop_eff || oldest_drop)) begin
            count_d = count_q + 1'b1;
        end else if (!gnt_any && pop_eff) begin
            count_d = count_q - 1'b1;
        end
    end

    // Drop counter and collision flag
    logic [DropCntWidth-1:0]      drop_cnt_q, drop_cnt_d;
    logic [DropCntWidth+IncW-1:0] drop_sum;
    logic                         collision_q, collision_d;

    always_comb begin
        drop_sum = {{IncW{1'b0}}, drop_cnt_q}
                 + {{DropCntWidth{1'b0}}, stage_drops + IncW'(oldest_drop)};
        if (drop_clr_i) begin
            drop_cnt_d = '0;
        end else if (|drop_sum[DropCntWidth +: IncW]) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = drop_sum[DropCntWidth-1:0];
        end
        collision_d = drop_clr_i ? 1'b0 : (collision_q | collision_set);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tab_valid_q <= '0;
            for (int i = 0; i < TabSize; i++) begin
                tab_addr_q[i] <= '0;
                tab_meta_q[i] <= '0;
            end
            stage_valid_q <= '0;
            for (int c = 0; c < NumChannels; c++) begin
                stage_q[c] <= '0;
            end
            for (int i = 0; i < NumStoredErrors; i++) begin
                fifo_q[i] <= '0;
            end
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rr_q        <= '0;
            drop_cnt_q  <= '0;
            collision_q <= 1'b0;
        end else begin
            tab_valid_q   <= tab_valid_d;
            tab_addr_q    <= tab_addr_d;
            tab_meta_q    <= tab_meta_d;
            stage_valid_q <= stage_valid_d;
            stage_q       <= stage_d;
            fifo_q        <= fifo_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            rr_q          <= rr_d;
            drop_cnt_q    <= drop_cnt_d;
            collision_q   <= collision_d;
        end
    end

    rec_t head;
    assign head = (count_q != '0) ? fifo_q[rptr_q] : '0;

    assign err_irq_o           = (count_q != '0);
    assign err_code_o          = head.err;
    assign err_addr_o          = head.addr;
    assign err_meta_o          = head.meta;
    assign err_chan_o          = head.chan;
    assign err_id_o            = head.id;
    assign err_unknown_o       = head.unknown;
    assign err_fifo_overflow_o = fifo_full;
    assign drop_cnt_o          = drop_cnt_q;
    assign id_collision_o      = collision_q;

endmodule

// File: tb/tb_bus_err_unit_id.sv
// tb/tb_bus_err_unit_id.sv - directed self-checking bench for bus_err_unit_id
module tb_bus_err_unit_id;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid, rsp_valid, rsp_last;
    logic [3:0]  req_id, rsp_id;
    logic [95:0] req_addr;
    logic [1:0]  req_meta;
    logic [5:0]  rsp_err;
    logic        drop_clr, pop;

    logic        irq0, unk0, ovf0, coll0, meta0, chan0;
    logic [2:0]  code0;
    logic [47:0] addr0;
    logic [1:0]  id0;
    logic [7:0]  drop0;

    logic        irq1, unk1, ovf1, coll1, meta1, chan1;
    logic [2:0]  code1;
    logic [47:0] addr1;
    logic [1:0]  id1;
    logic [1:0]  drop1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_err_unit_id dut0 (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(1'b0),
        .req_valid_i(req_valid), .req_id_i(req_id), .req_addr_i(req_addr), .req_meta_i(req_meta),
        .rsp_valid_i(rsp_valid), .rsp_id_i(rsp_id), .rsp_last_i(rsp_last), .rsp_err_i(rsp_err),
        .drop_clr_i(drop_clr), .err_fifo_pop_i(pop),
        .err_irq_o(irq0), .err_code_o(code0), .err_addr_o(addr0), .err_meta_o(meta0),
        .err_chan_o(chan0), .err_id_o(id0), .err_unknown_o(unk0),
        .err_fifo_overflow_o(ovf0), .drop_cnt_o(drop0), .id_collision_o(coll0)
    );

    bus_err_unit_id #(.DropCntWidth(2), .DropOldest(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .testmode_i(1'b0),
        .req_valid_i(req_valid), .req_id_i(req_id), .req_addr_i(req_addr), .req_meta_i(req_meta),
        .rsp_valid_i(rsp_valid), .rsp_id_i(rsp_id), .rsp_last_i(rsp_last), .rsp_err_i(rsp_err),
        .drop_clr_i(drop_clr), .err_fifo_pop_i(pop),
        .err_irq_o(irq1), .err_code_o(code1), .err_addr_o(addr1), .err_meta_o(meta1),
        .err_chan_o(chan1), .err_id_o(id1), .err_unknown_o(unk1),
        .err_fifo_overflow_o(ovf1), .drop_cnt_o(drop1), .id_collision_o(coll1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0; req_id = '0; req_addr = '0; req_meta = '0;
        rsp_valid = '0; rsp_id = '0; rsp_last = '0; rsp_err = '0;
        drop_clr = 1'b0; pop = 1'b0;
    endtask

    task automatic req(input int ch, input logic [1:0] id, input logic [47:0] a);
        req_valid[ch] = 1'b1;
        req_id[ch*2 +: 2] = id;
        req_addr[ch*48 +: 48] = a;
    endtask

    task automatic rsp(input int ch, input logic [1:0] id, input logic last, input logic [2:0] err);
        rsp_valid[ch] = 1'b1;
        rsp_id[ch*2 +: 2] = id;
        rsp_last[ch] = last;
        rsp_err[ch*3 +: 3] = err;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    logic [2:0] exp0 [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [2:0] exp1 [4] = '{3'd6, 3'd7, 3'd1, 3'd2};

    initial begin
        idle();
        tick();
        tick();
        check_eq("rst_irq", irq0, 0);
        check_eq("rst_code", code0, 0);
        check_eq("rst_addr", addr0, 0);
        check_eq("rst_unknown", unk0, 0);
        check_eq("rst_ovf", ovf0, 0);
        check_eq("rst_drop", drop0, 0);
        check_eq("rst_coll", coll0, 0);
        rst_n = 1'b1;
        tick();

        // Basic in-order error with latency check
        req(0, 2'd1, 48'h1000); tick(); idle();
        rsp(0, 2'd1, 1'b1, 3'd2); tick(); idle();
        check_eq("t1_irq_n1", irq0, 0);
        tick();
        check_eq("t1_irq_n2", irq0, 1);
        check_eq("t1_code", code0, 2);
        check_eq("t1_addr", addr0, 48'h1000);
        check_eq("t1_chan", chan0, 0);
        check_eq("t1_id", id0, 1);
        check_eq("t1_unknown", unk0, 0);
        do_pop();
        check_eq("t1_irq_popped", irq0, 0);
        do_pop();
        check_eq("t1_pop_empty_irq", irq0, 0);
        check_eq("t1_pop_empty_ovf", ovf0, 0);

        // Out-of-order responses across IDs on ch1
        req(1, 2'd0, 48'hA0); tick(); idle();
        req(1, 2'd3, 48'hB0); tick(); idle();
        rsp(1, 2'd3, 1'b1, 3'd1); tick(); idle();
        rsp(1, 2'd0, 1'b1, 3'd1); tick(); idle();
        tick(); tick();
        check_eq("t2_addr_first", addr0, 48'hB0);
        check_eq("t2_chan_first", chan0, 1);
        check_eq("t2_id_first", id0, 3);
        do_pop();
        check_eq("t2_addr_second", addr0, 48'hA0);
        check_eq("t2_id_second", id0, 0);
        do_pop();
        check_eq("t2_irq_empty", irq0, 0);

        // Concurrent errors, round-robin from channel 0
        reset_pulse();
        rsp(0, 2'd0, 1'b1, 3'd4);
        rsp(1, 2'd1, 1'b1, 3'd5);
        tick(); idle();
        tick(); tick();
        check_eq("t3_chan_first", chan0, 0);
        check_eq("t3_code_first", code0, 4);
        check_eq("t3_unknown_first", unk0, 1);
        do_pop();
        check_eq("t3_chan_second", chan0, 1);
        check_eq("t3_code_second", code0, 5);
        check_eq("t3_id_second", id0, 1);
        check_eq("t3_drop", drop0, 0);
        do_pop();

        // Same-cycle request and response-last on the same ID
        req(0, 2'd1, 48'h100); tick(); idle();
        req(0, 2'd1, 48'h200); rsp(0, 2'd1, 1'b1, 3'd1); tick(); idle();
        rsp(0, 2'd1, 1'b1, 3'd2); tick(); idle();
        tick(); tick();
        check_eq("t4_addr_old", addr0, 48'h100);
        check_eq("t4_code_old", code0, 1);
        do_pop();
        check_eq("t4_addr_new", addr0, 48'h200);
        check_eq("t4_unknown_new", unk0, 0);
        check_eq("t4_no_coll", coll0, 0);
        do_pop();

        // ID collision poisons the entry
        req(0, 2'd2, 48'h22); tick(); idle();
        req(0, 2'd2, 48'h33); tick(); idle();
        check_eq("t5_coll_set", coll0, 1);
        rsp(0, 2'd2, 1'b1, 3'd3); tick(); idle();
        tick(); tick();
        check_eq("t5_code", code0, 3);
        check_eq("t5_addr", addr0, 0);
        check_eq("t5_unknown", unk0, 1);
        check_eq("t5_id", id0, 2);
        do_pop();
        drop_clr = 1'b1; tick(); drop_clr = 1'b0;
        check_eq("t5_coll_clr", coll0, 0);

        // Asynchronous reset mid-operation
        rsp(0, 2'd0, 1'b1, 3'd6); tick(); idle();
        tick(); tick();
        check_eq("t6_irq_before", irq0, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_irq_async_rst", irq0, 0);
        rst_n = 1'b1;
        tick();

        // Overflow: DropOldest=0 (dut0) vs DropOldest=1 with 2-bit counter (dut1)
        reset_pulse();
        for (int i = 1; i <= 6; i++) begin
            rsp(0, 2'd0, 1'b1, 3'(i));
            tick();
            idle();
        end
        tick(); tick(); tick(); tick();
        check_eq("t7_ovf0", ovf0, 1);
        check_eq("t7_drop0", drop0, 1);
        check_eq("t7_head0", code0, 1);
        check_eq("t7_ovf1", ovf1, 1);
        check_eq("t7_drop1", drop1, 2);
        check_eq("t7_head1", code1, 3);

        for (int i = 0; i < 3; i++) begin
            rsp(0, 2'd0, 1'b1, (i == 0) ? 3'd7 : 3'(i));
            tick();
            idle();
        end
        tick(); tick(); tick(); tick();
        check_eq("t8_drop0", drop0, 4);
        check_eq("t8_drop1_sat", drop1, 3);

        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t8_drain0_%0d", i), code0, exp0[i]);
            if (i < 4) check_eq($sformatf("t8_drain1_%0d", i), code1, exp1[i]);
            else       check_eq("t8_drain1_empty", irq1, 0);
            do_pop();
        end
        tick(); tick();
        check_eq("t8_irq0_empty", irq0, 0);

        drop_clr = 1'b1; tick(); drop_clr = 1'b0;
        check_eq("t9_drop0_clr", drop0, 0);
        check_eq("t9_drop1_clr", drop1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
